// File: rtl/peripheral_bus_pkg.sv
// peripheral_bus_pkg: register map, control-bit positions and UART state encoding
package peripheral_bus_pkg;
  localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED  = 32'h4000_000C;
  localparam logic [31:0] ADDR_SW   = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI = 32'h4000_0014;
  localparam logic [31:0] ADDR_TXD  = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD  = 32'h4000_001C;
  localparam logic [31:0] ADDR_UCON = 32'h4000_0020;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;
  localparam int UCON_TXDONE = 0;
  localparam int UCON_RXVALID = 1;
  localparam int UCON_TXBUSY = 2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/peripheral_bus_uart_core.sv
// uart_core: fixed-baud 8N1 transmitter and receiver with a two-flop RX synchroniser
module uart_core
  import peripheral_bus_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       rx_in,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done_pulse,
  output logic [7:0] rx_data,
  output logic       rx_valid_pulse
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BIT_CYC / 2 - 1);
  uart_state_e   tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic          tx_q, tx_line_d, tx_end, rx_end;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  assign tx_end         = tx_cnt_q == BIT_END;
  assign rx_end         = rx_cnt_q == (rx_st_q == START ? HALF_END : BIT_END);
  assign tx_out         = tx_q;
  assign tx_busy        = tx_st_q != IDLE;
  assign tx_done_pulse  = tx_st_q == STOP && tx_end;
  assign rx_valid_pulse = rx_st_q == STOP && rx_end;
  assign rx_data        = rx_sh_q;
  // the line is driven one cycle behind the state so the output stays glitch-free
  assign tx_line_d = tx_st_q == START ? 1'b0 : tx_st_q == DATA ? tx_sh_q[tx_bit_q] : 1'b1;
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_cnt_d = (tx_st_q == IDLE || tx_end) ? '0 : tx_cnt_q + 1'b1;
    case (tx_st_q)
      IDLE:  if (tx_start) begin
        tx_st_d = START;
        tx_sh_d = tx_data;
      end
      START: if (tx_end) begin
        tx_st_d  = DATA;
        tx_bit_d = '0;
      end
      DATA:  if (tx_end) begin
        tx_bit_d = tx_bit_q + 1'b1;
        tx_st_d  = tx_bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (tx_end) tx_st_d = IDLE;
    endcase
  end
  // START waits half a bit so every later sample lands mid-bit
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_cnt_d = (rx_st_q == IDLE || rx_end) ? '0 : rx_cnt_q + 1'b1;
    case (rx_st_q)
      IDLE:  if (rx_prev_q && !rx_s2_q) rx_st_d = START;
      START: if (rx_end) begin
        rx_st_d  = rx_s2_q ? IDLE : DATA;
        rx_bit_d = '0;
      end
      DATA:  if (rx_end) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        rx_st_d  = rx_bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (rx_end) rx_st_d = IDLE;
    endcase
  end
  // sync flops reset low so a line held low since reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_st_q   <= IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_q      <= 1'b1;
      rx_st_q   <= IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_s1_q   <= 1'b0;
      rx_s2_q   <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_q      <= tx_line_d;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_s1_q   <= rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end
endmodule

// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped timer, LED/switch, digital tube and UART block at 0x40000000
module peripheral_bus
  import peripheral_bus_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  input  logic [7:0]  switch,
  output logic [11:0] digi,
  output logic        irqout,
  output logic        UART_TX,
  input  logic        UART_RX
);
  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d, txd_q, txd_d, rxd_q, rxd_d;
  logic [11:0] digi_q, digi_d;
  logic        done_q, done_d, rxv_q, rxv_d;
  logic        tx_start, tx_busy, tx_done_pulse, rx_valid_pulse, tl_wrap;
  logic [7:0]  rx_data;
  logic [2:0]  ucon;
  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_uart (
    .clk            (clk),
    .reset          (reset),
    .tx_start       (tx_start),
    .tx_data        (wdata[7:0]),
    .rx_in          (UART_RX),
    .tx_out         (UART_TX),
    .tx_busy        (tx_busy),
    .tx_done_pulse  (tx_done_pulse),
    .rx_data        (rx_data),
    .rx_valid_pulse (rx_valid_pulse)
  );
  assign led      = led_q;
  assign digi     = digi_q;
  assign irqout   = tcon_q[TCON_IE] & tcon_q[TCON_IS];
  assign tx_start = wr && addr == ADDR_TXD && !tx_busy;
  assign tl_wrap  = tcon_q[TCON_EN] && tl_q == '1;
  always_comb begin
    ucon               = '0;
    ucon[UCON_TXDONE]  = done_q;
    ucon[UCON_RXVALID] = rxv_q;
    ucon[UCON_TXBUSY]  = tx_busy;
  end
  always_comb begin
    rdata = '0;
    if (rd)
      case (addr)
        ADDR_TH:   rdata = th_q;
        ADDR_TL:   rdata = tl_q;
        ADDR_TCON: rdata = {29'd0, tcon_q};
        ADDR_LED:  rdata = {24'd0, led_q};
        ADDR_SW:   rdata = {24'd0, switch};
        ADDR_DIGI: rdata = {20'd0, digi_q};
        ADDR_TXD:  rdata = {24'd0, txd_q};
        ADDR_RXD:  rdata = {24'd0, rxd_q};
        ADDR_UCON: rdata = {29'd0, ucon};
        default:   rdata = '0;
      endcase
  end
  // CPU writes to TL/TCON take priority over the counter in the same cycle
  always_comb begin
    th_d   = wr && addr == ADDR_TH ? wdata : th_q;
    tl_d   = wr && addr == ADDR_TL ? wdata : !tcon_q[TCON_EN] ? tl_q : tl_wrap ? th_q : tl_q + 32'd1;
    tcon_d = tcon_q;
    tcon_d[TCON_IS] = tcon_q[TCON_IS] | (tl_wrap & tcon_q[TCON_IE]);
    tcon_d = wr && addr == ADDR_TCON ? wdata[2:0] : tcon_d;
    led_d  = wr && addr == ADDR_LED ? wdata[7:0] : led_q;
    digi_d = wr && addr == ADDR_DIGI ? wdata[11:0] : digi_q;
    txd_d  = tx_start ? wdata[7:0] : txd_q;
    rxd_d  = rx_valid_pulse ? rx_data : rxd_q;
    done_d = tx_done_pulse | (done_q & !(rd && addr == ADDR_UCON) & !tx_start);
    rxv_d  = rx_valid_pulse | (rxv_q & !(rd && addr == ADDR_RXD));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      led_q  <= '0;
      digi_q <= '0;
      txd_q  <= '0;
      rxd_q  <= '0;
      done_q <= 1'b0;
      rxv_q  <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
      digi_q <= digi_d;
      txd_q  <= txd_d;
      rxd_q  <= rxd_d;
      done_q <= done_d;
      rxv_q  <= rxv_d;
    end
  end
endmodule

// File: tb/tb_peripheral_bus.sv
// tb_peripheral_bus: randomized register, timer and UART frame checks against a behavioural model
module tb_peripheral_bus;
  localparam int CLK_FREQ = 200;
  localparam int BAUD     = 10;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004, A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED = 32'h4000_000C, A_SW = 32'h4000_0010, A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_TXD = 32'h4000_0018, A_RXD = 32'h4000_001C, A_UCON = 32'h4000_0020;
  logic        clk = 0, reset = 0, rd = 0, wr = 0, UART_RX = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [7:0]  led, sw = 0;
  logic [11:0] digi;
  logic        irqout, UART_TX;
  int          checks = 0, errors = 0;
  logic [7:0]  m_led, m_sw, m_txd, m_rxd, b1, b2;
  logic [11:0] m_digi;
  logic        m_rxv = 0, m_txdone = 0;
  logic [31:0] th;
  peripheral_bus #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
    .led(led), .switch(sw), .digi(digi), .irqout(irqout), .UART_TX(UART_TX), .UART_RX(UART_RX)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1; addr = a; wdata = d;
    @(posedge clk);
    #1 wr = 0;
  endtask
  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    rd = 1; addr = a;
    #1 check(tag, rdata, exp);
    @(posedge clk);
    #1 rd = 0;
  endtask
  function automatic logic [31:0] ucon_exp(input logic busy);
    return {29'd0, busy, m_rxv, m_txdone};
  endfunction
  task automatic tx_frame(input logic [7:0] b, input bit poke);
    bus_write(A_TXD, {24'd0, b});
    m_txd = b; m_txdone = 0;
    fork
      for (int k = 0; k < 10; k++) begin
        logic eb;
        eb = k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
        repeat (k == 0 ? 1 + BIT / 2 : BIT) @(posedge clk);
        #1 check($sformatf("tx_bit%0d_%h", k, b), {31'd0, UART_TX}, {31'd0, eb});
      end
      begin
        repeat (2 * BIT) @(posedge clk);
        read_check("ucon_busy", A_UCON, ucon_exp(1'b1));
        if (poke) begin
          bus_write(A_TXD, 32'h55);
          read_check("txd_hold", A_TXD, {24'd0, m_txd});
        end
      end
    join
    repeat (BIT) @(posedge clk);
    m_txdone = 1;
    read_check("ucon_done", A_UCON, ucon_exp(1'b0));
    m_txdone = 0;
    read_check("ucon_done_clr", A_UCON, ucon_exp(1'b0));
  endtask
  task automatic rx_frame(input logic [7:0] b);
    for (int k = 0; k < 10; k++) begin
      UART_RX = k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
      repeat (BIT) @(negedge clk);
    end
    m_rxd = b; m_rxv = 1;
  endtask
  task automatic rx_read(input string tag);
    read_check({tag, "_valid"}, A_UCON, ucon_exp(1'b0));
    read_check({tag, "_data"}, A_RXD, {24'd0, m_rxd});
    m_rxv = 0;
    read_check({tag, "_clr"}, A_UCON, ucon_exp(1'b0));
  endtask
  initial begin
    m_rxd = 0; m_txd = 0;
    repeat (3) @(negedge clk);
    check("rst_led", {24'd0, led}, 32'd0);
    check("rst_digi", {20'd0, digi}, 32'd0);
    check("rst_irq", {31'd0, irqout}, 32'd0);
    check("rst_tx", {31'd0, UART_TX}, 32'd1);
    reset = 1;
    read_check("rst_tcon", A_TCON, 32'd0);
    read_check("rst_ucon", A_UCON, 32'd0);
    read_check("rst_rxd", A_RXD, 32'd0);
    for (int i = 0; i < 4; i++) begin
      m_led  = i == 0 ? 8'h5A : 8'($urandom);
      m_digi = i == 0 ? 12'hABC : 12'($urandom);
      m_sw   = i == 0 ? 8'h3C : 8'($urandom);
      bus_write(A_LED, {24'd0, m_led});
      bus_write(A_DIGI, {20'd0, m_digi});
      bus_write(32'h4000_0024, $urandom);
      bus_write(A_SW, $urandom);
      sw = m_sw;
      check("led_out", {24'd0, led}, {24'd0, m_led});
      check("digi_out", {20'd0, digi}, {20'd0, m_digi});
      read_check("led_rd", A_LED, {24'd0, m_led});
      read_check("digi_rd", A_DIGI, {20'd0, m_digi});
      read_check("sw_rd", A_SW, {24'd0, m_sw});
      read_check("unmapped_rd", 32'h4000_0024, 32'd0);
    end
    @(negedge clk);
    addr = A_LED; rd = 0;
    #1 check("rd_low", rdata, 32'd0);
    for (int i = 0; i < 2; i++) begin
      th = i == 0 ? 32'h10 : $urandom_range(32'hFFFF);
      bus_write(A_TH, th);
      bus_write(A_TL, 32'hFFFF_FFFE);
      bus_write(A_TCON, 32'd3);
      read_check("tl_fe", A_TL, 32'hFFFF_FFFE);
      read_check("tl_ff", A_TL, 32'hFFFF_FFFF);
      read_check("tl_reload", A_TL, th);
      check("irq_set", {31'd0, irqout}, 32'd1);
      read_check("tcon_is", A_TCON, 32'd7);
      bus_write(A_TCON, 32'd1);
      check("irq_clr", {31'd0, irqout}, 32'd0);
      bus_write(A_TL, 32'hFFFF_FFFF);
      repeat (2) @(posedge clk);
      read_check("tcon_no_ie", A_TCON, 32'd1);
      check("irq_no_ie", {31'd0, irqout}, 32'd0);
      bus_write(A_TCON, 32'd0);
      bus_write(A_TL, 32'd5);
      repeat (3) @(posedge clk);
      read_check("tl_stopped", A_TL, 32'd5);
    end
    UART_RX = 1;
    repeat (BIT) @(negedge clk);
    rx_frame(8'hCD);
    rx_read("rx_cd");
    rx_frame(8'hBF);
    rx_read("rx_bf");
    UART_RX = 0;
    repeat (3) @(negedge clk);
    UART_RX = 1;
    repeat (2 * BIT) @(negedge clk);
    read_check("rx_glitch", A_UCON, ucon_exp(1'b0));
    for (int i = 0; i < 3; i++) begin
      b1 = 8'($urandom); b2 = 8'($urandom);
      rx_frame(b1);
      rx_frame(b2);
      rx_read("rx_overwrite");
    end
    tx_frame(8'hAF, 1);
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom), i[0]);
    bus_write(A_TXD, {24'd0, 8'($urandom)});
    repeat (BIT + 3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1 check("midrst_tx", {31'd0, UART_TX}, 32'd1);
    check("midrst_led", {24'd0, led}, 32'd0);
    @(negedge clk);
    reset = 1;
    m_rxv = 0; m_txdone = 0; m_rxd = 0;
    read_check("midrst_ucon", A_UCON, 32'd0);
    read_check("midrst_txd", A_TXD, 32'd0);
    UART_RX = 0;
    repeat (3 * BIT) @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    UART_RX = 1;
    repeat (12 * BIT) @(negedge clk);
    read_check("midrst_rx_ucon", A_UCON, 32'd0);
    read_check("midrst_rxd", A_RXD, 32'd0);
    tx_frame(8'($urandom), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
